// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store unit.
//   LSU_MEM_WORDS_DEF : default data-memory depth in 32-bit words
//   F3_*              : RISC-V load/store width/sign codes
//   lsu_state_e       : FSM state encoding (WRITE only with LSU_SUBWORD_EN)
// Macro: LSU_SUBWORD_EN enables byte/half accesses.
package lsu_pkg;

    localparam int unsigned LSU_MEM_WORDS_DEF = 1024;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
`ifdef LSU_SUBWORD_EN
        ST_WRITE  = 2'd2,
`endif
        ST_RESP   = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if -- request, response and data-memory signals of the LSU.
//   req_*  : execute-stage request (valid/ready handshake)
//   rsp_*  : response to the consumer (valid/ready handshake)
//   mem_*  : word-aligned data-memory strobes, address, write and read data
// modport slave  : the LSU side
// modport master : execute stage / consumer / memory side
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align -- combinational lane handling for the load/store unit.
//   funct3     : width/sign code of the latched request
//   byte_off   : addr[1:0] of the latched request
//   rdata      : word read from data memory
//   wdata      : right-aligned store data
//   load_data  : selected lane, sign- or zero-extended
//   merge_word : rdata with the target lane replaced by store data
//                (plain wdata for full-word stores)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{byte_off, 3'b000} +: 8];
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase

        merge_word = rdata;
        case (funct3)
            F3_B: merge_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (byte_off[1]) merge_word[31:16] = wdata[15:0];
                else             merge_word[15:0]  = wdata[15:0];
            end
            default: merge_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- single-outstanding load/store unit in front of a
// combinational-read data memory.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load_store_unit_if.slave (request, response, memory)
//   MEM_WORDS  : memory depth in words; byte addresses >= 4*MEM_WORDS fault
// Macro: LSU_SUBWORD_EN enables byte/half loads and read-modify-write
// stores; without it only LW/SW are legal and WRITE does not exist.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | memory access: load read, SW write, or SB/SH read for merge
// WRITE  | SB/SH write of the merged word (LSU_SUBWORD_EN only)
// RESP   | rsp_valid high until rsp_ready
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = LSU_MEM_WORDS_DEF
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
`ifdef LSU_SUBWORD_EN
    logic [31:0] merge_q, merge_d;
`endif

    logic        req_err;
    logic        f3_illegal;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] load_data;
    logic [31:0] merge_word;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    lsu_align u_align (
        .funct3     (f3_q),
        .byte_off   (addr_q[1:0]),
        .rdata      (bus.mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    // Classification of the request currently on the bus.
    always_comb begin
        f3_illegal   = 1'b0;
        misaligned   = 1'b0;
        out_of_range = 1'b0;
`ifdef LSU_SUBWORD_EN
        // 011 stores are rejected too: there is no 64-bit access.
        if (bus.req_we) f3_illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
        else            f3_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
`else
        f3_illegal = (bus.req_funct3 != F3_W);
`endif
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        // Word-index compare avoids overflow of 4*MEM_WORDS.
        out_of_range = ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS);
        req_err      = f3_illegal || misaligned || out_of_range;
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef LSU_SUBWORD_EN
        merge_d     = merge_q;
`endif
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d        = bus.req_we;
                    f3_d        = bus.req_funct3;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = req_err;
                    state_d     = req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_addr = {addr_q[31:2], 2'b00};
                if (!we_q) begin
                    mem_read    = 1'b1;
                    rsp_rdata_d = load_data;
                    state_d     = ST_RESP;
                end else if (f3_q == F3_W) begin
                    mem_write = 1'b1;
                    mem_wdata = merge_word;
                    state_d   = ST_RESP;
                end
`ifdef LSU_SUBWORD_EN
                else begin
                    mem_read = 1'b1;
                    merge_d  = merge_word;
                    state_d  = ST_WRITE;
                end
`endif
            end
`ifdef LSU_SUBWORD_EN
            ST_WRITE: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_write = 1'b1;
                mem_wdata = merge_q;
                state_d   = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
`ifdef LSU_SUBWORD_EN
            merge_q     <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef LSU_SUBWORD_EN
            merge_q     <= merge_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
- REQ-001 SHALL have parameter MEM_WORDS, default 1024: data-memory depth in 32-bit words; byte addresses >= MEM_WORDS*4 are out of range.
- REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
- REQ-004 SHALL have port req_valid, input, 1: execute stage presents a memory request.
- REQ-005 SHALL have port req_ready, output, 1: unit can accept a request.
- REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
- REQ-007 SHALL have port req_funct3, input, 3: RISC-V width/sign code (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
- REQ-008 SHALL have port req_addr, input, 32: byte address.
- REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
- REQ-010 SHALL have port rsp_valid, output, 1: response available.
- REQ-011 SHALL have port rsp_ready, input, 1: consumer takes the response.
- REQ-012 SHALL have port rsp_rdata, output, 32: extended load data; 0 for stores and errors.
- REQ-013 SHALL have port rsp_err, output, 1: misaligned, out-of-range or illegal request.
- REQ-014 SHALL have ports mem_read and mem_write, output, 1 each: data-memory strobes.
- REQ-015 SHALL have ports mem_addr and mem_wdata, output, 32 each: word-aligned address (bits 1:0 = 0) and write word.
- REQ-016 SHALL have port mem_rdata, input, 32: combinational read word from data memory.

Function
- REQ-017 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP; req_ready = (state == IDLE).
- REQ-018 SHALL accept on req_valid && req_ready, latching req_we, req_funct3, req_addr and req_wdata.
- REQ-019 SHALL, on accept of an error request, go IDLE->RESP with rsp_err = 1 and assert no memory strobe. Error requests are: half misaligned (addr[0]), word misaligned (addr[1:0] != 0), out of range, load funct3 in {011,110,111}, store funct3[2] = 1.
- REQ-020 SHALL, for legal requests, go IDLE->ACCESS and drive mem_addr = {addr[31:2],2'b00} for the whole of ACCESS and WRITE.
- REQ-021 SHALL, for a load in ACCESS: assert mem_read, capture the lane selected by addr[1:0] (LB/LBU byte, LH/LHU half at addr[1]), sign-extend for 000/001 or zero-extend for 100/101 into rsp_rdata, then go RESP.
- REQ-022 SHALL, for SW in ACCESS: assert mem_write with mem_wdata = req_wdata, then go RESP.
- REQ-023 SHALL, for SB/SH in ACCESS: assert mem_read and register mem_rdata with the target byte/half replaced by req_wdata[7:0]/[15:0]. It SHALL then go to WRITE, assert mem_write with the merged word, and go RESP.
- REQ-024 SHALL hold rsp_valid = 1 and stable rsp_rdata/rsp_err in RESP until rsp_ready, then return to IDLE. The response and a new accept SHALL NOT occur in the same cycle.
- REQ-025 SHALL have latencies accept->rsp_valid of 2 cycles for loads and SW, 3 cycles for SB/SH, and 1 cycle for errors.
- REQ-026 SHALL never assert mem_read and mem_write in the same cycle, and SHALL drive both 0 outside ACCESS/WRITE.

Reset
- REQ-027 SHALL, on rst_n low, immediately force state IDLE and drive rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write, mem_addr and mem_wdata to 0. A reset during ACCESS/WRITE SHALL abort the operation with no write issued after reset asserts.
- REQ-028 SHALL raise req_ready in the first cycle after rst_n deasserts.

Configuration
- REQ-029 SHALL compile in sub-word support when macro LSU_SUBWORD_EN is defined (REQ-021 byte/half lanes, REQ-023 read-modify-write).
- REQ-030 SHALL, without LSU_SUBWORD_EN, treat every funct3 other than 010 as illegal (rsp_err = 1), and the WRITE state SHALL not exist.

Structure
- REQ-031 SHALL place the state encoding, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and MEM_WORDS default in a shared package lsu_pkg.
- REQ-032 SHALL contain one sub-module lsu_align: combinational lane extract/extend for loads and byte/half merge for stores.

Verification
- REQ-033 SHALL cover: memory word 0x8070_F0FF at byte 0x10, LB addr 0x10 -> rsp_rdata 0xFFFF_FFFF; LBU -> 0x0000_00FF; LH addr 0x12 -> 0xFFFF_8070.
- REQ-034 SHALL cover: SB wdata 0x0000_00AB to addr 0x13 over word 0x1122_3344 -> one mem_write of 0xAB22_3344, rsp_valid 3 cycles after accept.
- REQ-035 SHALL cover: LW addr 0x0000_0006 -> rsp_err 1, rsp_rdata 0, no mem_read/mem_write, rsp_valid 1 cycle after accept.
- REQ-036 SHALL cover: SW to addr 0x0000_1000 with MEM_WORDS 1024 -> rsp_err 1, no write; LW addr 0x0FFC -> legal.
- REQ-037 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready 0 throughout.
- REQ-038 SHALL cover: rst_n pulsed low during WRITE of SH -> mem_write drops immediately, memory unchanged, req_ready 1 after release.
